div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- Initiator side of the divider handshake: accepts RISC-V M-extension divide/remainder requests (DIV, DIVU, REM, REMU) from the execute stage over valid/ready.
- Converts signed operands to magnitudes and drives the unsigned divider through div_enable / div_finished.
- Applies sign fixup and the RISC-V divide-by-zero and overflow rules, then returns a tagged result over valid/ready.
- Sits between the core execute stage and the divider instance.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- TAG_WIDTH, 5, destination-register tag carried with each request.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- req_op_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- rs1_i  in  DATA_WIDTH  dividend
- rs2_i  in  DATA_WIDTH  divisor
- req_tag_i  in  TAG_WIDTH  request tag
- flush_i  in  1  kill in-flight request
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_data_o  out  DATA_WIDTH  quotient or remainder
- rsp_tag_o  out  TAG_WIDTH  tag of response
- div_enable_o  out  1  one-cycle start pulse to divider
- dividend_o  out  DATA_WIDTH  unsigned dividend magnitude; stable from the pulse until finish
- divisor_o  out  DATA_WIDTH  unsigned divisor magnitude; stable from the pulse until finish
- div_finished_i  in  1  divider done (level)
- result_div_i  in  DATA_WIDTH  unsigned quotient
- result_rem_i  in  DATA_WIDTH  unsigned remainder

Behaviour:
- Reset values: req_ready_o=1, rsp_valid_o=0, div_enable_o=0, rsp_data_o=0, rsp_tag_o=0, dividend_o=0, divisor_o=0, state=IDLE. Reset in any state, including mid-divide, forces these values; a later divider finish is ignored.
- States and transitions:
  - IDLE: req_ready_o=1. A handshake (valid & ready & !flush_i) latches op, tag, operand signs and magnitudes.
  - Signed ops: magnitude = two's-complement abs. abs(MIN)=MIN as an unsigned value.
  - Special cases bypass the divider and go straight to RESP (latency 1: rsp_valid_o high in the cycle after acceptance):
    - divisor==0: quotient=all-ones, remainder=rs1.
    - Signed op with rs1==MIN and rs2==-1: quotient=MIN, remainder=0.
  - Otherwise go to ISSUE.
  - ISSUE: div_enable_o=1 for exactly one cycle, then WAIT.
  - WAIT: completion is a rising edge of div_finished_i (current high, registered previous low). A level left high from an earlier operation never completes a new one. On completion, fix signs and go to RESP:
    - Quotient is negated when operand signs differ (signed ops only).
    - Remainder takes the sign of the dividend.
    - Select quotient or remainder per op.
  - RESP: rsp_valid_o=1; rsp_data_o and rsp_tag_o held stable until rsp_ready_i. On handshake go to IDLE. Back-to-back: a new request is accepted only in the cycle after the response handshake, i.e. there is no same-cycle pass-through.
  - DRAIN: entered on flush_i while in ISSUE or WAIT. req_ready_o=0. Waits for the finish rising edge, discards the result, then goes to IDLE.
- flush_i in IDLE blocks acceptance in that cycle. flush_i in RESP drops rsp_valid_o next cycle and goes to IDLE.
- req_ready_o=1 only in IDLE; 0 in all other states.
- Simultaneous flush_i and completion in WAIT: flush wins, result discarded, go to IDLE directly.
- Total latency for a divider op = divider latency + 3 cycles (accept, ISSUE, fixup register).
- All arithmetic is DATA_WIDTH wide; negation wraps modulo 2^DATA_WIDTH.

Decomposition:
- Package kprim_div_pkg: div_op_e enum (DIV, DIVU, REM, REMU), div_state_e enum (IDLE, ISSUE, WAIT, RESP, DRAIN), and an is_signed(op) function.
- One combinational sub-module, div_sign_fixup: inputs are unsigned quotient, unsigned remainder, both operand signs and op; output is the final result. It is shared with the bypass path for selecting the special-case result.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2; divider returns q=3, r=1 -> rsp_data_o=0xFFFFFFFD; REM with same operands -> 0xFFFFFFFF; dividend_o=7, divisor_o=2.
- DIVU rs1=100, rs2=0 -> no div_enable_o pulse, rsp_valid_o 1 cycle after acceptance, data=0xFFFFFFFF; REMU with same operands -> data=100.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> bypass, data=0x80000000; REM with same operands -> data=0.
- div_finished_i held high from the previous op, new DIVU 50/7 issued -> no response until finished falls and rises again; then data=7, tag echoed.
- flush_i asserted in WAIT -> req_ready_o=0 until the finish edge, no rsp_valid_o, then next request REMU 50/7 returns 1.
- rsp_ready_i held low for 5 cycles in RESP -> rsp_data_o and rsp_tag_o stable, req_ready_o=0; reset asserted in WAIT -> all outputs reach reset values next cycle and the late finish is ignored.

Source files
------------

// File: rtl/kprim_div_pkg.sv
// Shared types for the divide issue controller: operation and FSM state encodings,
// plus helpers that classify an operation.
package kprim_div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'd0,
      DIVU = 2'd1,
      REM  = 2'd2,
      REMU = 2'd3
   } div_op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      DRAIN = 3'd4
   } div_state_e;

   function automatic logic is_signed(input div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_rem(input div_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/div_sign_fixup.sv
// Turns unsigned quotient/remainder magnitudes into the architectural result:
// quotient negated on sign mismatch, remainder follows the dividend sign.
module div_sign_fixup
   import kprim_div_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] quot_u,
   input  logic [DATA_WIDTH-1:0] rem_u,
   input  logic                  sign_dividend,
   input  logic                  sign_divisor,
   input  div_op_e               op,
   output logic [DATA_WIDTH-1:0] result
);

   logic [DATA_WIDTH-1:0] quot;
   logic [DATA_WIDTH-1:0] rem;

   always_comb begin
      quot = quot_u;
      rem  = rem_u;
      if (is_signed(op) && (sign_dividend ^ sign_divisor)) begin
         quot = -quot_u;
      end
      if (is_signed(op) && sign_dividend) begin
         rem = -rem_u;
      end
      result = is_rem(op) ? rem : quot;
   end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller between the execute stage and an unsigned divider: takes
// DIV/DIVU/REM/REMU requests, drives the divider and returns a tagged result.
module div_issue_ctrl
   import kprim_div_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            req_op_i,
   input  logic [DATA_WIDTH-1:0] rs1_i,
   input  logic [DATA_WIDTH-1:0] rs2_i,
   input  logic [TAG_WIDTH-1:0]  req_tag_i,
   input  logic                  flush_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic [TAG_WIDTH-1:0]  rsp_tag_o,
   output logic                  div_enable_o,
   output logic [DATA_WIDTH-1:0] dividend_o,
   output logic [DATA_WIDTH-1:0] divisor_o,
   input  logic                  div_finished_i,
   input  logic [DATA_WIDTH-1:0] result_div_i,
   input  logic [DATA_WIDTH-1:0] result_rem_i,
   output div_state_e            state_o
);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are
   // both high; valid never waits on ready, and payload is held while valid && !ready.

   localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] ONES_VAL = '1;

   div_state_e            state_q, state_d;
   div_op_e               op_q, req_op;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic                  sign1_q, sign2_q, fin_prev_q;
   logic [DATA_WIDTH-1:0] dividend_q, divisor_q, rsp_data_q;
   logic [TAG_WIDTH-1:0]  rsp_tag_q;
   logic                  load_req, load_rsp, accept, done;
   logic                  rs1_neg, rs2_neg, div_zero, overflow, bypass;
   logic [DATA_WIDTH-1:0] rs1_mag, rs2_mag;
   logic [DATA_WIDTH-1:0] fix_quot, fix_rem, fix_result;
   logic                  fix_s1, fix_s2;
   div_op_e               fix_op;

   assign req_op   = div_op_e'(req_op_i);
   assign accept   = (state_q == IDLE) && req_valid_i && !flush_i;
   assign rs1_neg  = is_signed(req_op) && rs1_i[DATA_WIDTH-1];
   assign rs2_neg  = is_signed(req_op) && rs2_i[DATA_WIDTH-1];
   assign rs1_mag  = rs1_neg ? -rs1_i : rs1_i;
   assign rs2_mag  = rs2_neg ? -rs2_i : rs2_i;
   assign div_zero = (rs2_i == '0);
   assign overflow = is_signed(req_op) && (rs1_i == MIN_VAL) && (rs2_i == ONES_VAL);
   assign bypass   = div_zero || overflow;
   // Edge, not level: a finish still high from a previous op must not complete this one.
   assign done     = div_finished_i && !fin_prev_q;

   // In IDLE the fixup selects the special-case result; signs forced clear so no negation.
   assign fix_quot = (state_q == IDLE) ? (div_zero ? ONES_VAL : MIN_VAL) : result_div_i;
   assign fix_rem  = (state_q == IDLE) ? (div_zero ? rs1_i : '0) : result_rem_i;
   assign fix_s1   = (state_q == IDLE) ? 1'b0 : sign1_q;
   assign fix_s2   = (state_q == IDLE) ? 1'b0 : sign2_q;
   assign fix_op   = (state_q == IDLE) ? req_op : op_q;

   div_sign_fixup #(.DATA_WIDTH(DATA_WIDTH)) u_fixup (
      .quot_u        (fix_quot),
      .rem_u         (fix_rem),
      .sign_dividend (fix_s1),
      .sign_divisor  (fix_s2),
      .op            (fix_op),
      .result        (fix_result)
   );

   always_comb begin
      state_d  = state_q;
      load_req = 1'b0;
      load_rsp = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               load_req = 1'b1;
               if (bypass) begin
                  load_rsp = 1'b1;
                  state_d  = RESP;
               end else begin
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: state_d = flush_i ? DRAIN : WAIT;
         WAIT: begin
            if (flush_i) begin
               state_d = done ? IDLE : DRAIN;
            end else if (done) begin
               load_rsp = 1'b1;
               state_d  = RESP;
            end
         end
         RESP:  if (flush_i || rsp_ready_i) state_d = IDLE;
         DRAIN: if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= DIV;
         tag_q      <= '0;
         sign1_q    <= 1'b0;
         sign2_q    <= 1'b0;
         fin_prev_q <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         rsp_data_q <= '0;
         rsp_tag_q  <= '0;
      end else begin
         state_q    <= state_d;
         fin_prev_q <= div_finished_i;
         if (load_req) begin
            op_q       <= req_op;
            tag_q      <= req_tag_i;
            sign1_q    <= rs1_neg;
            sign2_q    <= rs2_neg;
            dividend_q <= rs1_mag;
            divisor_q  <= rs2_mag;
         end
         if (load_rsp) begin
            rsp_data_q <= fix_result;
            rsp_tag_q  <= (state_q == IDLE) ? req_tag_i : tag_q;
         end
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign rsp_valid_o  = (state_q == RESP);
   assign div_enable_o = (state_q == ISSUE);
   assign rsp_data_o   = rsp_data_q;
   assign rsp_tag_o    = rsp_tag_q;
   assign dividend_o   = dividend_q;
   assign divisor_o    = divisor_q;
   assign state_o      = state_q;

endmodule
